// File: rtl/address_sequencer.sv
// Windowed address generator: advances by STEP on completion requests inside a
// programmable [base, limit] window, then wraps to base or saturates and flags full.
module address_sequencer #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned STEP      = 1,
  parameter bit          COUNT_ALL = 1'b0,
  parameter bit          WRAP      = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] limit,
  input  logic [NUM_REQ-1:0] req,
  output logic [ADDR_W-1:0] address,
  output logic              busy,
  output logic              full,
  output logic              wrap_pulse,
  output logic              cfg_err
);

  localparam int unsigned CNT_W = $clog2(NUM_REQ + 1);
  localparam int unsigned SUM_W = ADDR_W + CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] base_q, limit_q;
  logic [ADDR_W-1:0] base_d, limit_d, address_d;
  logic              busy_d, full_d, wrap_d, err_d;
  logic [CNT_W-1:0]  req_cnt, req_mult;
  logic [SUM_W-1:0]  amt, sum;

  // Number of asserted request lines
  always_comb begin
    req_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_cnt = req_cnt + CNT_W'(req[i]);
    end
  end

  // Full-width sum so a window ending at the top of the range never rolls to 0
  always_comb begin
    req_mult = COUNT_ALL ? req_cnt : CNT_W'(|req);
    amt      = SUM_W'(STEP) * SUM_W'(req_mult);
    sum      = SUM_W'(address) + amt;
  end

  // Next-state and registered-output logic; priority abort > start > req
  always_comb begin
    state_d   = state;
    address_d = address;
    base_d    = base_q;
    limit_d   = limit_q;
    wrap_d    = 1'b0;
    err_d     = 1'b0;

    if (abort) begin
      state_d = IDLE;
    end else if (start) begin
      if (base <= limit) begin
        base_d    = base;
        limit_d   = limit;
        address_d = base;
        state_d   = RUN;
      end else begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end else begin
      case (state)
        RUN: begin
          if (amt != '0) begin
            if (sum <= SUM_W'(limit_q)) begin
              address_d = ADDR_W'(sum);
            end else if (WRAP) begin
              address_d = base_q;
              wrap_d    = 1'b1;
            end else begin
              address_d = limit_q;
              state_d   = FULL;
            end
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d != IDLE);
    full_d = (state_d == FULL);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      address    <= '0;
      base_q     <= '0;
      limit_q    <= '0;
      busy       <= 1'b0;
      full       <= 1'b0;
      wrap_pulse <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_d;
      address    <= address_d;
      base_q     <= base_d;
      limit_q    <= limit_d;
      busy       <= busy_d;
      full       <= full_d;
      wrap_pulse <= wrap_d;
      cfg_err    <= err_d;
    end
  end

endmodule
